// File: rtl/n64_vdemux_if.sv
// Bundle of the N64 multiplexed video bus and the demultiplexed outputs.
// hcnt_o exists only when VDEMUX_PIXEL_CNT_EN is defined.
interface n64_vdemux_if #(
  parameter int color_width = 7
);
  logic                         nDSYNC;
  logic [color_width-1:0]       D_i;
  logic [3:0]                   vinfo_i;
  logic [3:0]                   Sync_pre;
  logic [3:0]                   Sync_cur;
  logic [4+3*color_width-1:0]   vdata_o;
  logic                         vdata_valid_o;
  logic                         grp_err_o;
`ifdef VDEMUX_PIXEL_CNT_EN
  logic [9:0]                   hcnt_o;
`endif

  modport master (
    output nDSYNC, D_i, vinfo_i,
    input  Sync_pre, Sync_cur, vdata_o, vdata_valid_o, grp_err_o
`ifdef VDEMUX_PIXEL_CNT_EN
    , input hcnt_o
`endif
  );

  modport slave (
    input  nDSYNC, D_i, vinfo_i,
    output Sync_pre, Sync_cur, vdata_o, vdata_valid_o, grp_err_o
`ifdef VDEMUX_PIXEL_CNT_EN
    , output hcnt_o
`endif
  );
endinterface

// File: rtl/n64_vdemux.sv
// N64 video bus demultiplexer: sync word + R/G/B words -> one qualified pixel word.
// Optional VDEMUX_PIXEL_CNT_EN adds a saturating per-line pixel counter (hcnt_o).
module n64_vdemux #(
  parameter int color_width = 7
) (
  input  logic         VCLK,
  input  logic         RST,
  n64_vdemux_if.slave  bus
);

  localparam int VW = 4 + 3 * color_width;

  logic [3:0]             sync_pre_q, sync_pre_d;
  logic [3:0]             sync_cur_q, sync_cur_d;
  logic [color_width-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   f_r_q, f_r_d, f_g_q, f_g_d, f_b_q, f_b_d;
  logic                   seen_q, seen_d;
  logic [VW-1:0]          vdata_q, vdata_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [1:0]             data_cnt;
`ifdef VDEMUX_PIXEL_CNT_EN
  logic [9:0]             hcnt_q, hcnt_d;
  logic                   hsync_fall;
`endif

  assign data_cnt = bus.vinfo_i[3:2];

`ifdef VDEMUX_PIXEL_CNT_EN
  // nHSYNC is active low: a 1 -> 0 step between consecutive groups starts a line
  assign hsync_fall = sync_pre_q[1] & ~sync_cur_q[1];
`endif

  always_comb begin
    sync_pre_d = sync_pre_q;
    sync_cur_d = sync_cur_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    f_r_d      = f_r_q;
    f_g_d      = f_g_q;
    f_b_d      = f_b_q;
    seen_d     = seen_q;
    vdata_d    = vdata_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
`ifdef VDEMUX_PIXEL_CNT_EN
    hcnt_d     = hcnt_q;
`endif

    if (!bus.nDSYNC) begin
      // Colour words arriving before the first sync after reset are never emitted
      if (f_b_q && seen_q) begin
        vdata_d = {sync_cur_q, r_q, g_q, b_q};
        valid_d = 1'b1;
`ifdef VDEMUX_PIXEL_CNT_EN
        if (hsync_fall)
          hcnt_d = '0;
        else if (hcnt_q != '1)
          hcnt_d = hcnt_q + 10'd1;
`endif
      end else begin
        err_d = seen_q;
      end
      sync_pre_d = sync_cur_q;
      sync_cur_d = bus.D_i[3:0];
      seen_d     = 1'b1;
      f_r_d      = 1'b0;
      f_g_d      = 1'b0;
      f_b_d      = 1'b0;
    end else begin
      unique case (data_cnt)
        2'd1: begin
          r_d   = bus.D_i;
          f_r_d = 1'b1;
        end
        2'd2: begin
          g_d   = bus.D_i;
          f_g_d = f_r_q;
        end
        2'd3: begin
          b_d   = bus.D_i;
          f_b_d = f_g_q;
        end
        default: begin
          f_r_d = 1'b0;
          f_g_d = 1'b0;
          f_b_d = 1'b0;
          err_d = seen_q;
        end
      endcase
    end
  end

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      sync_pre_q <= '1;
      sync_cur_q <= '1;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      f_r_q      <= 1'b0;
      f_g_q      <= 1'b0;
      f_b_q      <= 1'b0;
      seen_q     <= 1'b0;
      vdata_q    <= {4'hF, {(3*color_width){1'b0}}};
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef VDEMUX_PIXEL_CNT_EN
      hcnt_q     <= '0;
`endif
    end else begin
      sync_pre_q <= sync_pre_d;
      sync_cur_q <= sync_cur_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      f_r_q      <= f_r_d;
      f_g_q      <= f_g_d;
      f_b_q      <= f_b_d;
      seen_q     <= seen_d;
      vdata_q    <= vdata_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef VDEMUX_PIXEL_CNT_EN
      hcnt_q     <= hcnt_d;
`endif
    end
  end

  assign bus.Sync_pre      = sync_pre_q;
  assign bus.Sync_cur      = sync_cur_q;
  assign bus.vdata_o       = vdata_q;
  assign bus.vdata_valid_o = valid_q;
  assign bus.grp_err_o     = err_q;
`ifdef VDEMUX_PIXEL_CNT_EN
  assign bus.hcnt_o        = hcnt_q;
`endif

endmodule

// File: tb/tb_n64_vdemux.sv
// Directed self-checking bench for n64_vdemux; hcnt checks need VDEMUX_PIXEL_CNT_EN.
module tb_n64_vdemux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [24:0] exp_v;

  n64_vdemux_if #(.color_width(7)) bus ();

  n64_vdemux #(.color_width(7)) dut (
    .VCLK (clk),
    .RST  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Drive one bus word at the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic nd, input logic [6:0] d, input logic [1:0] cnt);
    @(negedge clk);
    bus.nDSYNC  = nd;
    bus.D_i     = d;
    bus.vinfo_i = {cnt, 2'b00};
    @(posedge clk);
    #1;
  endtask

  task automatic sync_w(input logic [3:0] s);
    step(1'b0, {3'b000, s}, 2'd0);
  endtask

  task automatic rgb(input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    step(1'b1, r, 2'd1);
    step(1'b1, g, 2'd2);
    step(1'b1, b, 2'd3);
  endtask

  initial begin
    bus.nDSYNC  = 1'b1;
    bus.D_i     = '0;
    bus.vinfo_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sync_pre", {28'd0, bus.Sync_pre}, 32'hF);
    chk("rst_sync_cur", {28'd0, bus.Sync_cur}, 32'hF);
    chk("rst_vdata", {7'd0, bus.vdata_o}, 32'h01E0_0000);
    chk("rst_valid", {31'd0, bus.vdata_valid_o}, 32'd0);
    chk("rst_err", {31'd0, bus.grp_err_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1/2: first full group, closing sync emits it
    sync_w(4'hF);
    chk("t1_first_sync_valid", {31'd0, bus.vdata_valid_o}, 32'd0);
    chk("t1_first_sync_err", {31'd0, bus.grp_err_o}, 32'd0);
    rgb(7'h11, 7'h22, 7'h33);
    chk("t1_no_early_valid", {31'd0, bus.vdata_valid_o}, 32'd0);
    sync_w(4'h5);
    exp_v = {4'hF, 7'h11, 7'h22, 7'h33};
    chk("t1_valid", {31'd0, bus.vdata_valid_o}, 32'd1);
    chk("t1_vdata", {7'd0, bus.vdata_o}, {7'd0, exp_v});
    chk("t1_err", {31'd0, bus.grp_err_o}, 32'd0);
    chk("t2_sync_pre", {28'd0, bus.Sync_pre}, 32'hF);
    chk("t2_sync_cur", {28'd0, bus.Sync_cur}, 32'h5);

    // Test 3: B word missing
    step(1'b1, 7'h44, 2'd1);
    chk("t1_valid_one_cycle", {31'd0, bus.vdata_valid_o}, 32'd0);
    step(1'b1, 7'h55, 2'd2);
    sync_w(4'hA);
    chk("t3_err", {31'd0, bus.grp_err_o}, 32'd1);
    chk("t3_valid", {31'd0, bus.vdata_valid_o}, 32'd0);
    chk("t3_vdata_hold", {7'd0, bus.vdata_o}, {7'd0, exp_v});
    chk("t3_sync_pre", {28'd0, bus.Sync_pre}, 32'h5);
    chk("t3_sync_cur", {28'd0, bus.Sync_cur}, 32'hA);
    step(1'b1, 7'h01, 2'd1);
    chk("t3_err_one_cycle", {31'd0, bus.grp_err_o}, 32'd0);

    // Test 4: fourth data word overruns the group
    step(1'b1, 7'h02, 2'd2);
    step(1'b1, 7'h03, 2'd3);
    chk("t4_no_err_before", {31'd0, bus.grp_err_o}, 32'd0);
    step(1'b1, 7'h04, 2'd0);
    chk("t4_overrun_err", {31'd0, bus.grp_err_o}, 32'd1);
    sync_w(4'h3);
    chk("t4_no_emit", {31'd0, bus.vdata_valid_o}, 32'd0);
    chk("t4_vdata_hold", {7'd0, bus.vdata_o}, {7'd0, exp_v});

    // Test 5: reset during the G word
    sync_w(4'hC);
    step(1'b1, 7'h01, 2'd1);
    @(negedge clk);
    bus.nDSYNC  = 1'b1;
    bus.D_i     = 7'h02;
    bus.vinfo_i = {2'd2, 2'b00};
    rst = 1'b1;
    #2;
    chk("t5_async_sync_cur", {28'd0, bus.Sync_cur}, 32'hF);
    chk("t5_async_vdata", {7'd0, bus.vdata_o}, 32'h01E0_0000);
    @(negedge clk);
    rst = 1'b0;
    sync_w(4'hF);
    chk("t5_close_valid", {31'd0, bus.vdata_valid_o}, 32'd0);
    chk("t5_close_err", {31'd0, bus.grp_err_o}, 32'd0);
    rgb(7'h0A, 7'h0B, 7'h0C);
    sync_w(4'h7);
    exp_v = {4'hF, 7'h0A, 7'h0B, 7'h0C};
    chk("t5_valid", {31'd0, bus.vdata_valid_o}, 32'd1);
    chk("t5_vdata", {7'd0, bus.vdata_o}, {7'd0, exp_v});
    chk("t5_err", {31'd0, bus.grp_err_o}, 32'd0);

`ifdef VDEMUX_PIXEL_CNT_EN
    // Test 6: emissions so far since reset: {F} vs pre F -> 1
    chk("t6_hcnt_after_t5", {22'd0, bus.hcnt_o}, 32'd1);
    rgb(7'h10, 7'h20, 7'h30);
    sync_w(4'hD);
    chk("t6_hcnt_no_fall", {22'd0, bus.hcnt_o}, 32'd2);
    for (int unsigned i = 0; i < 5; i++) begin
      rgb(7'h10, 7'h20, 7'h30);
      sync_w(4'hD);
      chk("t6_valid", {31'd0, bus.vdata_valid_o}, 32'd1);
      chk("t6_hcnt_seq", {22'd0, bus.hcnt_o}, i);
    end
    for (int unsigned i = 0; i < 1100; i++) begin
      rgb(7'h01, 7'h02, 7'h03);
      sync_w(4'hD);
    end
    chk("t6_hcnt_sat", {22'd0, bus.hcnt_o}, 32'd1023);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
